a_reg: RTL and testbench

Accumulator register A of the NibblER 4-bit datapath: a WIDTH-bit, edge-triggered storage register with synchronous clear and load-enable. It holds the working operand between ALU operations and drives its contents continuously onto the datapath. An optional zero-status output feeds the control unit's branch logic.

---
 rtl/nibbler_pkg.sv | 5 +
 rtl/a_reg_if.sv | 19 +
 rtl/a_reg_dff_en.sv | 26 ++
 rtl/a_reg.sv | 30 +++
 tb/tb_a_reg.sv | 107 ++++++++++
 5 files changed

// File: rtl/nibbler_pkg.sv
// Shared NibblER datapath types: the native nibble width and its vector type.
package nibbler_pkg;
  localparam int NIBBLE_W = 4;
  typedef logic [NIBBLE_W-1:0] nibble_t;
endpackage

// File: rtl/a_reg_if.sv
// Load/readback bus of accumulator A. zero exists only with A_REG_ZERO_FLAG_EN.
interface a_reg_if
  import nibbler_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
);
  logic             enable;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
`ifdef A_REG_ZERO_FLAG_EN
  logic             zero;

  modport master (output enable, output D, input Q, input zero);
  modport slave  (input enable, input D, output Q, output zero);
`else
  modport master (output enable, output D, input Q);
  modport slave  (input enable, input D, output Q);
`endif
endinterface

// File: rtl/a_reg_dff_en.sv
// Single-bit storage cell: synchronous active-low clear beats load enable, else hold.
module dff_en (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);
  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (!reset) begin
      q_d = 1'b0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/a_reg.sv
// Accumulator register A: WIDTH dff_en cells; optional zero status when
// A_REG_ZERO_FLAG_EN is defined.
module a_reg
  import nibbler_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
) (
  input  logic    clk,
  input  logic    reset,
  a_reg_if.slave  bus
);
  logic [WIDTH-1:0] q_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en u_dff (
      .clk   (clk),
      .reset (reset),
      .en    (bus.enable),
      .d     (bus.D[i]),
      .q     (q_bits[i])
    );
  end

  assign bus.Q = q_bits;

`ifdef A_REG_ZERO_FLAG_EN
  // Combinational from the stored value so branch logic sees it in the same cycle as Q.
  assign bus.zero = (q_bits == '0);
`endif
endmodule

// File: tb/tb_a_reg.sv
// Directed table-driven bench for a_reg; covers the zero flag when A_REG_ZERO_FLAG_EN is defined.
module tb_a_reg;
  import nibbler_pkg::*;

  typedef struct {
    logic    rst_n;
    logic    en;
    nibble_t d;
    nibble_t exp_q;
    string   name;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  a_reg_if #(.WIDTH(NIBBLE_W)) bus ();

  a_reg #(.WIDTH(NIBBLE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_q(input string name, input nibble_t exp_q);
    checks++;
    if (bus.Q !== exp_q) begin
      errors++;
      $display("FAIL %s: Q=%h expected %h", name, bus.Q, exp_q);
    end
`ifdef A_REG_ZERO_FLAG_EN
    checks++;
    if (bus.zero !== (exp_q == 4'h0)) begin
      errors++;
      $display("FAIL %s_zero: zero=%b expected %b", name, bus.zero, (exp_q == 4'h0));
    end
`endif
  endtask

  vec_t vecs[16];

  initial begin
    errors = 0;
    checks = 0;
    vecs[0]  = '{1'b0, 1'b1, 4'h3, 4'h0, "reset"};
    vecs[1]  = '{1'b1, 1'b0, 4'h3, 4'h0, "hold0"};
    vecs[2]  = '{1'b1, 1'b0, 4'h3, 4'h0, "hold1"};
    vecs[3]  = '{1'b1, 1'b0, 4'h3, 4'h0, "hold2"};
    vecs[4]  = '{1'b1, 1'b1, 4'h3, 4'h3, "load3"};
    vecs[5]  = '{1'b1, 1'b1, 4'h2, 4'h2, "load2"};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 4'h2, "disable0"};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 4'h2, "disable1"};
    vecs[8]  = '{1'b1, 1'b1, 4'hA, 4'hA, "loadA"};
    vecs[9]  = '{1'b0, 1'b1, 4'h5, 4'h0, "prio_reset"};
    vecs[10] = '{1'b1, 1'b1, 4'hF, 4'hF, "first_after_clr"};
    vecs[11] = '{1'b1, 1'b1, 4'h1, 4'h1, "b2b_1"};
    vecs[12] = '{1'b1, 1'b1, 4'h8, 4'h8, "b2b_8"};
    vecs[13] = '{1'b1, 1'b1, 4'h0, 4'h0, "load_zero"};
    vecs[14] = '{1'b1, 1'b1, 4'h7, 4'h7, "load7"};
    vecs[15] = '{1'b0, 1'b0, 4'h9, 4'h0, "clear_idle"};

    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.D      = 4'h0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset      = vecs[i].rst_n;
      bus.enable = vecs[i].en;
      bus.D      = vecs[i].d;
      @(posedge clk);
      #1;
      check_q(vecs[i].name, vecs[i].exp_q);
    end

    // Load 6, then wiggle enable/reset/D between edges, all back to idle before the edge.
    @(negedge clk);
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.D      = 4'h6;
    @(posedge clk);
    #1;
    check_q("preload6", 4'h6);
    @(negedge clk);
    bus.enable = 1'b0;
    #1 bus.D = 4'hF;
    #1 bus.enable = 1'b1;
    #1 reset = 1'b0;
    #1 check_q("mid_cycle", 4'h6);
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.D      = 4'h0;
    @(posedge clk);
    #1;
    check_q("edge_only", 4'h6);
    @(posedge clk);
    #1;
    check_q("edge_only_hold", 4'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
